// File: rtl/driver_trace_pkg.sv
// Shared types and sizing for the trace-buffer readout path.
package driver_trace_pkg;

  localparam int unsigned TRACE_BUF_DATA_WIDTH = 256;
  localparam int unsigned TRACE_BUF_ADDR_WIDTH = 15;
  localparam int unsigned TRACE_DEPTH          = 2**TRACE_BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } rd_state_t;

  typedef struct packed {
    logic [TRACE_BUF_DATA_WIDTH-1:0] data;
    logic                            last;
  } trace_beat_t;

endpackage

// File: rtl/trace_rd_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head word is visible on dout while !empty.
module trace_rd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 257
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/driver_trace_readout.sv
// Trace buffer reader: drains the rd_len newest entries (oldest first) from BRAM port B to a stream.
// Optional feature: define TRACE_RD_OVERRUN_EN to add the sticky overrun output.
module driver_trace_readout #(
  parameter int unsigned TRACE_BUF_DATA_WIDTH = driver_trace_pkg::TRACE_BUF_DATA_WIDTH,
  parameter int unsigned TRACE_BUF_ADDR_WIDTH = driver_trace_pkg::TRACE_BUF_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY           = 2,
  parameter int unsigned OUT_FIFO_DEPTH       = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [TRACE_BUF_ADDR_WIDTH:0]   rd_len,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] wr_addr,
  input  logic                            wr_en,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] bram_addrb,
  output logic                            bram_enb,
  input  logic [TRACE_BUF_DATA_WIDTH-1:0] bram_doutb,
  output logic [TRACE_BUF_DATA_WIDTH-1:0] m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic                            done
`ifdef TRACE_RD_OVERRUN_EN
  ,
  output logic                            overrun
`endif
);

  import driver_trace_pkg::*;

  localparam int unsigned AW = TRACE_BUF_ADDR_WIDTH;
  localparam int unsigned DW = TRACE_BUF_DATA_WIDTH;
  localparam int unsigned CW = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [AW:0] DEPTH_LEN = {1'b1, {AW{1'b0}}};

  rd_state_t             state, state_nxt;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           remaining;
  logic [AW:0]           len_clamped;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [RD_LATENCY-1:0] last_sr;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           in_flight;
  logic [CW:0]           occupancy;
  logic [DW:0]           fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full_unused;
  logic                  start_ok;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;

  assign len_clamped = rd_len[AW] ? DEPTH_LEN : rd_len;
  assign start_ok    = (state == IDLE) && start;

  // Credits are counted against FIFO entries plus reads still in the BRAM pipe.
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + (CW+1)'(vld_sr[i]);
    end
  end

  assign occupancy  = {1'b0, fifo_count} + in_flight;
  assign issue      = (state == READ) && (remaining != '0) &&
                      (occupancy < (CW+1)'(OUT_FIFO_DEPTH));
  assign issue_last = issue && (remaining == (AW+1)'(1));
  assign pop        = m_tvalid && m_tready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = (len_clamped == '0) ? FINISH : READ;
      READ:   if (issue_last) state_nxt = DRAIN;
      // Leave on the cycle the final beat is accepted so done follows it directly.
      DRAIN:  if ((in_flight == '0) &&
                  ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop)))
                state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      vld_sr    <= '0;
      last_sr   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        rd_ptr    <= wr_addr - len_clamped[AW-1:0];
        remaining <= len_clamped;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      vld_sr[0]  <= issue;
      last_sr[0] <= issue_last;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  trace_rd_fifo #(
    .DEPTH (OUT_FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (vld_sr[RD_LATENCY-1]),
    .din   ({last_sr[RD_LATENCY-1], bram_doutb}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .count (fifo_count)
  );

  assign bram_enb   = issue;
  assign bram_addrb = rd_ptr;
  assign m_tvalid   = !fifo_empty;
  assign m_tdata    = fifo_dout[DW-1:0];
  assign m_tlast    = m_tvalid && fifo_dout[DW];
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

`ifdef TRACE_RD_OVERRUN_EN
  logic [AW:0] wr_cnt;
  logic [AW:0] slack;

  // Writes counted from the start cycle; more than slack means the oldest unread entry was hit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_cnt  <= '0;
      slack   <= '0;
      overrun <= 1'b0;
    end else if (start_ok) begin
      wr_cnt  <= (AW+1)'(wr_en);
      slack   <= DEPTH_LEN - len_clamped;
      overrun <= 1'b0;
    end else if (busy) begin
      if (wr_en && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
      if ((state == READ) && (wr_cnt > slack)) overrun <= 1'b1;
    end
  end
`else
  logic unused_wr_en;
  assign unused_wr_en = wr_en;
`endif

endmodule

// File: tb/tb_driver_trace_readout.sv
// Directed self-checking bench for driver_trace_readout (default parameters, RD_LATENCY=2, FIFO depth 8).
module tb_driver_trace_readout;
  import driver_trace_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   rd_len = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] bram_addrb;
  logic          bram_enb;
  logic [DW-1:0] bram_doutb;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          busy;
  logic          done;
`ifdef TRACE_RD_OVERRUN_EN
  logic          overrun;
`endif

  driver_trace_readout dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .rd_len     (rd_len),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .bram_addrb (bram_addrb),
    .bram_enb   (bram_enb),
    .bram_doutb (bram_doutb),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .done       (done)
`ifdef TRACE_RD_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_word(input logic [AW-1:0] a);
    return {8{16'hBEEF, 1'b0, a}};
  endfunction

  // Two-cycle BRAM port B: address registered on enb, data one more stage later.
  logic [AW-1:0] bram_p0 = '0, bram_p1 = '0;
  always @(posedge clk) begin
    bram_p1 <= bram_p0;
    if (bram_enb) bram_p0 <= bram_addrb;
  end
  assign bram_doutb = mk_word(bram_p1);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int            cyc = 0;
  trace_beat_t   beat_q[$];
  int            beat_cyc_q[$];
  logic [AW-1:0] addr_q[$];
  int            done_n, done_cyc, busy_n, outstanding, max_out, first_enb, stall_err, start_cyc;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic clear_rec();
    beat_q.delete(); beat_cyc_q.delete(); addr_q.delete();
    done_n = 0; done_cyc = -1; busy_n = 0; outstanding = 0; max_out = 0;
    first_enb = -1; stall_err = 0;
  endtask

  task automatic tick();
    @(negedge clk); #1;
    if (rstn) begin
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
        stall_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (bram_enb) begin
        addr_q.push_back(bram_addrb);
        outstanding++;
        if (first_enb < 0) first_enb = cyc;
      end
      if (m_tvalid && m_tready) begin
        beat_q.push_back('{data: m_tdata, last: m_tlast});
        beat_cyc_q.push_back(cyc);
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin done_n++; done_cyc = cyc; end
      if (busy) busy_n++;
    end else begin
      prev_stall = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic issue_start(input logic [AW:0] len, input logic [AW-1:0] addr);
    rd_len = len; wr_addr = addr; start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    wr_addr = addr + 15'h0777;  // writer keeps moving; the window must not follow it
  endtask

  task automatic run_until_done(input int max_cyc, input int mode, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      m_tready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0);
      tick();
      if (done_n > 0) begin ok = 1; break; end
    end
    m_tready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    n_cmp++; if (bram_enb !== 1'b0) begin n_bad++; $display("FAIL reset_enb: got %b expected 0", bram_enb); end
    n_cmp++; if (bram_addrb !== '0) begin n_bad++; $display("FAIL reset_addrb: got %h expected 0", bram_addrb); end
    n_cmp++; if ({m_tvalid, m_tlast} !== 2'b00) begin n_bad++; $display("FAIL reset_stream: got valid/last %b expected 00", {m_tvalid, m_tlast}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
`ifdef TRACE_RD_OVERRUN_EN
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`endif
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok; int errs;
    clear_rec(); m_tready = 1'b1;
    issue_start(16'd4, 15'h0010);
    run_until_done(60, 0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout: done seen %b expected 1", ok); end
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= addr_q.size() || addr_q[i] !== 15'h000C + 15'(i)) errs++;
      if (i >= beat_q.size() || beat_q[i].data !== mk_word(15'h000C + 15'(i)) || beat_q[i].last !== (i == 3)) errs++;
    end
    n_cmp++; if (errs != 0 || addr_q.size() != 4 || beat_q.size() != 4) begin
      n_bad++; $display("FAIL basic_window: %0d bad, %0d reads %0d beats, expected 0 bad 4 reads 4 beats", errs, addr_q.size(), beat_q.size()); end
    n_cmp++; if (first_enb - start_cyc !== 1) begin n_bad++; $display("FAIL basic_enb_latency: got %0d expected 1", first_enb - start_cyc); end
    n_cmp++; if (beat_cyc_q.size() < 1 || beat_cyc_q[0] - start_cyc !== 4) begin
      n_bad++; $display("FAIL basic_beat_latency: got %0d expected 4", beat_cyc_q.size() > 0 ? beat_cyc_q[0] - start_cyc : -1); end
    n_cmp++; if (beat_cyc_q.size() < 1 || done_cyc !== beat_cyc_q[beat_cyc_q.size()-1] + 1) begin
      n_bad++; $display("FAIL basic_done_timing: done cycle %0d, last beat cycle %0d", done_cyc, beat_cyc_q.size() > 0 ? beat_cyc_q[beat_cyc_q.size()-1] : -1); end
    n_cmp++; if (done_n !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: pulses %0d busy %b expected 1 and 0", done_n, busy); end
  endtask

  task automatic test_wrap();
    bit ok; int errs;
    logic [AW-1:0] exp_a [5] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0002};
    clear_rec(); m_tready = 1'b1;
    issue_start(16'd5, 15'h0003);
    run_until_done(60, 0, ok);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i >= addr_q.size() || addr_q[i] !== exp_a[i]) errs++;
      if (i >= beat_q.size() || beat_q[i].data !== mk_word(exp_a[i]) || beat_q[i].last !== (i == 4)) errs++;
    end
    n_cmp++; if (!ok || errs != 0 || addr_q.size() != 5 || beat_q.size() != 5) begin
      n_bad++; $display("FAIL wrap_window: done %b, %0d bad, %0d reads %0d beats, expected 1/0/5/5", ok, errs, addr_q.size(), beat_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok; int errs;
    clear_rec();
    issue_start(16'd16, 15'h0200);
    run_until_done(400, 1, ok);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (i >= beat_q.size() || beat_q[i].data !== mk_word(15'h01F0 + 15'(i)) || beat_q[i].last !== (i == 15)) errs++;
    n_cmp++; if (!ok || errs != 0 || beat_q.size() != 16) begin
      n_bad++; $display("FAIL bp_beats: done %b, %0d bad, %0d beats, expected 1/0/16", ok, errs, beat_q.size()); end
    n_cmp++; if (max_out !== 8) begin n_bad++; $display("FAIL bp_credit_peak: outstanding peak %0d expected 8", max_out); end
    n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL bp_hold_stable: %0d unstable stall cycles expected 0", stall_err); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL bp_done_count: got %0d expected 1", done_n); end
  endtask

  task automatic test_zero_len();
    clear_rec(); m_tready = 1'b1;
    issue_start(16'd0, 15'h0055);
    rd_len = 16'd4; start = 1'b1;  // lands on the done cycle and must be ignored
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (addr_q.size() !== 0 || beat_q.size() !== 0) begin
      n_bad++; $display("FAIL zero_activity: %0d reads %0d beats expected 0/0", addr_q.size(), beat_q.size()); end
    n_cmp++; if (busy_n !== 1) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_n); end
    n_cmp++; if (done_n !== 1 || done_cyc !== start_cyc + 1) begin
      n_bad++; $display("FAIL zero_done: pulses %0d at offset %0d expected 1 at 1", done_n, done_cyc - start_cyc); end
  endtask

  task automatic test_full_buffer();
    bit ok; int errs_a, errs_d;
    clear_rec(); m_tready = 1'b1;
    issue_start(16'h8000, 15'h1234);
    ok = 0;
    rd_len = 16'd3;
    for (int i = 0; i < 34000; i++) begin
      start = (i == 100);
      tick();
      if (done_n > 0) begin ok = 1; break; end
    end
    start = 1'b0;
    tick();
    errs_a = 0; errs_d = 0;
    for (int i = 0; i < 32768; i++) begin
      if (i >= addr_q.size() || addr_q[i] !== 15'h1234 + 15'(i)) errs_a++;
      if (i >= beat_q.size() || beat_q[i].data !== mk_word(15'h1234 + 15'(i)) || beat_q[i].last !== (i == 32767)) errs_d++;
    end
    n_cmp++; if (!ok || addr_q.size() != 32768 || errs_a != 0) begin
      n_bad++; $display("FAIL full_addr: done %b, %0d reads, %0d bad, expected 1/32768/0", ok, addr_q.size(), errs_a); end
    n_cmp++; if (beat_q.size() != 32768 || errs_d != 0) begin
      n_bad++; $display("FAIL full_beats: %0d beats, %0d bad, expected 32768/0", beat_q.size(), errs_d); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL full_done_count: got %0d expected 1", done_n); end
  endtask

  task automatic test_reset_mid();
    bit ok; int errs;
    clear_rec(); m_tready = 1'b1;
    issue_start(16'd10, 15'h0100);
    for (int i = 0; i < 50 && beat_q.size() < 2; i++) tick();
    rstn = 1'b0;
    tick();
    n_cmp++; if ({bram_enb, m_tvalid, m_tlast, busy, done} !== 5'b0 || bram_addrb !== '0) begin
      n_bad++; $display("FAIL midrst_outputs: enb/valid/last/busy/done %b addrb %h expected 00000/0", {bram_enb, m_tvalid, m_tlast, busy, done}, bram_addrb); end
    n_cmp++; if (done_n !== 0 || beat_q.size() !== 2) begin
      n_bad++; $display("FAIL midrst_no_done: pulses %0d beats %0d expected 0/2", done_n, beat_q.size()); end
    rstn = 1'b1;
    tick();
    clear_rec();
    issue_start(16'd2, 15'h0400);
    run_until_done(60, 0, ok);
    errs = 0;
    for (int i = 0; i < 2; i++)
      if (i >= beat_q.size() || beat_q[i].data !== mk_word(15'h03FE + 15'(i)) || beat_q[i].last !== (i == 1)) errs++;
    n_cmp++; if (!ok || errs != 0 || beat_q.size() != 2 || done_n != 1) begin
      n_bad++; $display("FAIL midrst_restart: done %b, %0d bad, %0d beats, %0d pulses, expected 1/0/2/1", ok, errs, beat_q.size(), done_n); end
  endtask

`ifdef TRACE_RD_OVERRUN_EN
  task automatic test_overrun();
    bit ok;
    clear_rec(); m_tready = 1'b0;
    issue_start(16'd16, 15'h0800);
    wr_en = 1'b1;
    for (int i = 0; i < int'(TRACE_DEPTH); i++) tick();
    wr_en = 1'b0;
    n_cmp++; if (overrun !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL overrun_set: overrun %b busy %b expected 1/1", overrun, busy); end
    run_until_done(100, 0, ok);
    n_cmp++; if (!ok || overrun !== 1'b1 || beat_q.size() != 16) begin
      n_bad++; $display("FAIL overrun_sticky: done %b overrun %b beats %0d expected 1/1/16", ok, overrun, beat_q.size()); end
    clear_rec();
    issue_start(16'd1, 15'h0010);
    run_until_done(40, 0, ok);
    n_cmp++; if (!ok || overrun !== 1'b0) begin
      n_bad++; $display("FAIL overrun_clear: done %b overrun %b expected 1/0", ok, overrun); end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rec();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_full_buffer();
    test_reset_mid();
`ifdef TRACE_RD_OVERRUN_EN
    test_overrun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
